// File: rtl/ks_sub_pipe_16.sv
// ks_sub_pipe_16: two-stage pipelined 16-bit Kogge-Stone subtractor, a - b - bin.
// Valid/ready handshake on both sides; full backpressure with no bubbles.
// Optional build macro KS_SUB_SAT_EN: saturate diff on signed overflow.
module ks_sub_pipe_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        zero
);

  localparam int unsigned W = 16;

  // handshake state
  logic v1, v2, v1_nxt, v2_nxt;
  logic s1_adv, s2_adv, accept;

  // stage 1 combinational: preprocessing and prefix spans 1, 2
  logic [W-1:0] bn, g0, p0, gf, g1, g2;
  logic [W-1:2] p1;
  logic [W-1:4] p2;
  logic         cin;

  // stage 1 registers
  logic [W-1:0] s1_p, s1_g2;
  logic [W-1:4] s1_p2;
  logic         s1_cin, s1_a15, s1_b15;

  // stage 2 combinational: prefix spans 4, 8, sum and flags
  logic [W-1:0] g4, g8, c, diff_raw, diff_c;
  logic [W-1:8] p4;
  logic         bout_c, ovf_c, zero_c;

  // Handshake control and next pipeline occupancy
  always_comb begin
    s2_adv   = !v2 || out_ready;
    s1_adv   = v1 && s2_adv;
    in_ready = !v1 || s2_adv;
    accept   = in_valid && in_ready;
    v1_nxt   = accept || (v1 && !s1_adv);
    v2_nxt   = s2_adv ? v1 : v2;
  end

  // Subtraction is a + ~b + ~bin; borrow-in becomes carry-in folded into bit 0
  always_comb begin
    bn  = ~b;
    cin = ~bin;
    g0  = a & bn;
    p0  = a ^ bn;
    gf  = {g0[W-1:1], g0[0] | (p0[0] & cin)};
    g1  = gf;
    for (int i = 1; i < W; i++) g1[i] = gf[i] | (p0[i] & gf[i-1]);
    for (int i = 2; i < W; i++) p1[i] = p0[i] & p0[i-1];
    g2  = g1;
    for (int i = 2; i < W; i++) g2[i] = g1[i] | (p1[i] & g1[i-2]);
    for (int i = 4; i < W; i++) p2[i] = p1[i] & p1[i-2];
  end

  // Finish the prefix tree, form the difference and flags
  always_comb begin
    g4 = s1_g2;
    for (int i = 4; i < W; i++) g4[i] = s1_g2[i] | (s1_p2[i] & s1_g2[i-4]);
    for (int i = 8; i < W; i++) p4[i] = s1_p2[i] & s1_p2[i-4];
    g8 = g4;
    for (int i = 8; i < W; i++) g8[i] = g4[i] | (p4[i] & g4[i-8]);
    c        = {g8[W-2:0], s1_cin};
    diff_raw = s1_p ^ c;
    bout_c   = ~g8[W-1];
    ovf_c    = (s1_a15 ^ s1_b15) & (s1_a15 ^ diff_raw[W-1]);
`ifdef KS_SUB_SAT_EN
    if (ovf_c) diff_c = s1_a15 ? 16'h8000 : 16'h7FFF;
    else       diff_c = diff_raw;
`else
    diff_c   = diff_raw;
`endif
    zero_c   = ~|diff_c;
  end

  // Occupancy flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= v1_nxt;
      v2 <= v2_nxt;
    end
  end

  // Stage 1 capture on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_p   <= '0;
      s1_g2  <= '0;
      s1_p2  <= '0;
      s1_cin <= 1'b0;
      s1_a15 <= 1'b0;
      s1_b15 <= 1'b0;
    end else if (accept) begin
      s1_p   <= p0;
      s1_g2  <= g2;
      s1_p2  <= p2;
      s1_cin <= cin;
      s1_a15 <= a[W-1];
      s1_b15 <= b[W-1];
    end
  end

  // Stage 2 capture when stage 1 drains; holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (s1_adv) begin
      diff <= diff_c;
      bout <= bout_c;
      ovf  <= ovf_c;
      zero <= zero_c;
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_ks_sub_pipe_16.sv
// Bench for ks_sub_pipe_16: directed table, backpressure, reset and random streams.
module tb_ks_sub_pipe_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        out_valid, out_ready;
  logic [15:0] diff;
  logic        bout, ovf, zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vt[14];
  logic [18:0] exp_q[$];

  ks_sub_pipe_16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: native subtraction, overflow from the signed integer result
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] full;
    logic [15:0] d;
    logic        o;
    int          s;
    full = {1'b0, x} - {1'b0, y} - 17'(bi);
    d    = full[15:0];
    s    = int'($signed(x)) - int'($signed(y)) - (bi ? 1 : 0);
    o    = (s > 32767) || (s < -32768);
`ifdef KS_SUB_SAT_EN
    if (o) d = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {d, full[16], o, (d == 16'h0000)};
  endfunction

  function automatic vec_t mk(input logic [15:0] xa, input logic [15:0] xb, input logic xbi,
                              input logic [15:0] xd, input logic xbo, input logic xov, input logic xz);
    vec_t v;
    v.a = xa; v.b = xb; v.bin = xbi; v.d = xd; v.bo = xbo; v.ov = xov; v.z = xz;
    return v;
  endfunction

  // One beat into an idle pipe: absent after one edge, present after two
  task automatic apply_vec(input int i);
    a = vt[i].a; b = vt[i].b; bin = vt[i].bin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    check($sformatf("vec%0d_result", i), 32'({diff, bout, ovf, zero}),
          32'({vt[i].d, vt[i].bo, vt[i].ov, vt[i].z}));
  endtask

  // mode 0: out_ready low in cycles 3..6; mode 1: always ready; mode 2: random
  task automatic run_stream(input int n, input int mode);
    int          sent = 0;
    int          got = 0;
    int          c = 0;
    bit          prev_stall = 1'b0;
    logic [18:0] prev_out = '0;
    logic [18:0] e;
    while (got < n && c < n * 20 + 50) begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'({diff, bout, ovf, zero}), 32'(prev_out));
      end
      case (mode)
        0:       out_ready = (c < 3) || (c > 6);
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      bin = 1'($urandom);
      #1;
      if (mode == 0) check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'(out_ready));
      if (mode == 1) check($sformatf("tp_in_ready_c%0d", c), 32'(in_ready), 32'd1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("m%0d_beat%0d", mode, got), 32'({diff, bout, ovf, zero}), 32'(e));
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {diff, bout, ovf, zero};
      c++;
    end
    in_valid = 1'b0;
    check($sformatf("m%0d_beats_out", mode), 32'(got), 32'(n));
    if (mode == 1) check("tp_cycles", 32'(c), 32'(n + 2));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    vt[1]  = mk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vt[2]  = mk(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
`ifdef KS_SUB_SAT_EN
    vt[3]  = mk(16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    vt[4]  = mk(16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    vt[11] = mk(16'h8000, 16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    vt[12] = mk(16'hA5A5, 16'h5A5A, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
`else
    vt[3]  = mk(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    vt[4]  = mk(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    vt[11] = mk(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0);
    vt[12] = mk(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1, 1'b0);
`endif
    vt[5]  = mk(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vt[6]  = mk(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    vt[7]  = mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    vt[8]  = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    vt[9]  = mk(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    vt[10] = mk(16'h0001, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    vt[13] = mk(16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outputs", 32'({diff, bout, ovf, zero}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) apply_vec(i);
    @(negedge clk);

    run_stream(8, 0);
    run_stream(16, 1);

    // Reset with both stages full and output stalled
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h0000; b = 16'h0001; bin = 1'b0;
    @(negedge clk);
    a = 16'h0005; b = 16'h0003;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out", 32'({out_valid, diff, bout}), 32'({1'b1, 16'hFFFF, 1'b1}));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_outputs", 32'({diff, bout, ovf, zero}), 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_valid%0d", k), 32'(out_valid), 32'd0);
    end

    run_stream(10000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
